// File: rtl/a2f_pkg.sv
// a2f_pkg: shared types and constants for the IQ/CPU -> FTDI packet arbiter.
package a2f_pkg;

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      FIFO_PKT = 2'd1,
      CPU_PKT  = 2'd2
   } a2f_state_e;

   localparam logic       FROMFIFO  = 1'b0;
   localparam logic       FROMCPU   = 1'b1;
   localparam logic [7:0] HDR_MAGIC = 8'hA5;

endpackage

// File: rtl/a2f_arbiter_if.sv
// a2f_arbiter_if: FTDI read-stream bundle (read strobe in, word + status out).
interface a2f_arbiter_if #(
   parameter int unsigned FT_DATA_WIDTH = 32
);
   logic                     re_i;
   logic [FT_DATA_WIDTH-1:0] data_o;
   logic                     empty_o;
   logic                     enough_o;

   // master: the arbiter, which supplies words to the FTDI side
   modport master (input re_i, output data_o, empty_o, enough_o);
   // slave: the FTDI reader
   modport slave  (output re_i, input data_o, empty_o, enough_o);
endinterface

// File: rtl/a2f_iq_pack.sv
// a2f_iq_pack: places the packed I/Q pair into an FTDI word
// (I at bit 0, Q at QSTART_BIT_INDEX, all other bits zero).
module a2f_iq_pack #(
   parameter int unsigned FT_DATA_WIDTH    = 32,
   parameter int unsigned IQ_PAIR_WIDTH    = 24,
   parameter int unsigned QSTART_BIT_INDEX = 16
) (
   input  logic [IQ_PAIR_WIDTH-1:0] pair_i,
   output logic [FT_DATA_WIDTH-1:0] word_o
);
   localparam int unsigned HALF = IQ_PAIR_WIDTH / 2;

   // Spread the two halves of the pair into their word positions
   always_comb begin
      word_o                            = '0;
      word_o[HALF-1:0]                  = pair_i[HALF-1:0];
      word_o[QSTART_BIT_INDEX +: HALF]  = pair_i[IQ_PAIR_WIDTH-1:HALF];
   end
endmodule

// File: rtl/a2f_arbiter.sv
// a2f_arbiter: packet-level arbiter between the IQ sample FIFO and the CPU
// mailbox FIFO onto the single FTDI read stream. Source changes only on
// packet boundaries. Optional feature macro: A2F_HEADER_EN (word 0 of each
// packet becomes a header {A5, 7'b0, mode, seq[15:0]}).
module a2f_arbiter
   import a2f_pkg::*;
#(
   parameter int unsigned FT_DATA_WIDTH    = 32,
   parameter int unsigned IQ_PAIR_WIDTH    = 24,
   parameter int unsigned QSTART_BIT_INDEX = 16,
   parameter int unsigned PKT_LEN          = 256,
   parameter int unsigned SEQ_WIDTH        = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n,
   a2f_arbiter_if.master            ft,
   input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
   input  logic                     fifo_empty_i,
   input  logic                     fifo_enough_i,
   output logic                     fifo_re_o,
   output logic                     fifo_clk_o,
   input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
   input  logic                     cpu_empty_i,
   output logic                     cpu_re_o,
   output logic                     cpu_clk_o,
   output logic                     mode_o,
   output logic [SEQ_WIDTH-1:0]     seq_o
);
   localparam int unsigned        CNT_W    = $clog2(PKT_LEN);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PKT_LEN - 1);

   a2f_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   mode_q, mode_d;
   logic [SEQ_WIDTH-1:0]   seq_q, seq_d;

   logic [FT_DATA_WIDTH-1:0] iq_word;
   logic [FT_DATA_WIDTH-1:0] hdr_data;
   logic                     hdr_word;
   logic                     accept;

   assign fifo_clk_o = clk_i;
   assign cpu_clk_o  = clk_i;
   assign mode_o     = mode_q;
   assign seq_o      = seq_q;

   a2f_iq_pack #(
      .FT_DATA_WIDTH    (FT_DATA_WIDTH),
      .IQ_PAIR_WIDTH    (IQ_PAIR_WIDTH),
      .QSTART_BIT_INDEX (QSTART_BIT_INDEX)
   ) u_iq_pack (
      .pair_i (fifo_data_i),
      .word_o (iq_word)
   );

`ifdef A2F_HEADER_EN
   assign hdr_word = (state_q != ARB) && (cnt_q == '0);
   assign hdr_data = {HDR_MAGIC, 7'b0, mode_q, seq_q[15:0]};
`else
   assign hdr_word = 1'b0;
   assign hdr_data = '0;
`endif

   // Stream outputs and source read strobes, combinational from state and inputs
   always_comb begin
      ft.data_o   = '0;
      ft.empty_o  = 1'b1;
      ft.enough_o = 1'b0;
      fifo_re_o   = 1'b0;
      cpu_re_o    = 1'b0;
      unique case (state_q)
         FIFO_PKT: begin
            ft.enough_o = 1'b1;
            if (hdr_word) begin
               ft.data_o  = hdr_data;
               ft.empty_o = 1'b0;
            end else begin
               ft.data_o  = iq_word;
               ft.empty_o = fifo_empty_i;
               fifo_re_o  = ft.re_i & ~fifo_empty_i;
            end
         end
         CPU_PKT: begin
            // CPU packets never stall: an empty mailbox pads with zeros
            ft.enough_o = 1'b1;
            ft.empty_o  = 1'b0;
            if (hdr_word) begin
               ft.data_o = hdr_data;
            end else if (!cpu_empty_i) begin
               ft.data_o = cpu_data_i;
               cpu_re_o  = ft.re_i;
            end
         end
         default: ;
      endcase
   end

   assign accept = ft.re_i & ~ft.empty_o;

   // Next-state: source decision in ARB, word counting inside a packet
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      seq_d   = seq_q;
      unique case (state_q)
         ARB: begin
            // CPU first, but never twice in a row while the IQ FIFO is ready
            if (!cpu_empty_i && ((mode_q == FROMFIFO) || !fifo_enough_i)) begin
               state_d = CPU_PKT;
               mode_d  = FROMCPU;
            end else if (fifo_enough_i) begin
               state_d = FIFO_PKT;
               mode_d  = FROMFIFO;
            end
         end
         default: begin
            if (accept) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  seq_d   = seq_q + 1'b1;
                  state_d = ARB;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   // State, counter, mode and sequence registers
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB;
         cnt_q   <= '0;
         mode_q  <= FROMFIFO;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         seq_q   <= seq_d;
      end
   end
endmodule
